// File: rtl/counter_pkg.sv
// Shared types and constants for the digit counter block.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } cnt_state_t;

    localparam int DIGIT_W = 4;

    // Saturate a requested digit to the top of the count range.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] val,
                                                       input logic [DIGIT_W-1:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button followed by a rising-edge detector.
// pulse is high for one clk cycle per rising edge of din, however long din is held.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/digit_counter.sv
// Run/pause decade counter with prescaled tick and wrap carry for cascading digits.
// Optional parallel load is enabled with the DIGIT_COUNTER_LOAD_EN macro.
module digit_counter
    import counter_pkg::*;
#(
    parameter int TICK_DIV  = 10_000_000,
    parameter int MAX_DIGIT = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_btn,
    input  logic               dir,
    input  logic               clr,
`ifdef DIGIT_COUNTER_LOAD_EN
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
`endif
    output logic [DIGIT_W-1:0] counter,
    output logic               carry,
    output logic               running
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DIGIT_W-1:0] MAX_D      = DIGIT_W'(MAX_DIGIT);

    cnt_state_t         state;
    cnt_state_t         state_next;
    logic [PW-1:0]      presc;
    logic               toggle;
    logic               tick;
    logic               load_req;
    logic [DIGIT_W-1:0] load_digit;

    btn_sync_edge u_btn (
        .clk   (clk),
        .rst   (rst),
        .din   (run_btn),
        .pulse (toggle)
    );

`ifdef DIGIT_COUNTER_LOAD_EN
    assign load_req   = load & ~clr;
    assign load_digit = clamp_digit(load_val, MAX_D);
`else
    assign load_req   = 1'b0;
    assign load_digit = '0;
`endif

    assign tick = (state == RUN) && (presc == PRESC_LAST);

    // A load holds the current state even if a toggle arrives in the same cycle.
    always_comb begin
        state_next = state;
        if (clr) begin
            state_next = IDLE;
        end else if (!load_req && toggle) begin
            unique case (state)
                IDLE:    state_next = RUN;
                RUN:     state_next = PAUSE;
                PAUSE:   state_next = RUN;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == RUN);
        end
    end

    // Prescaler only advances while running; PAUSE keeps the partial count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (clr || load_req) begin
            presc <= '0;
        end else if (state == RUN) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
            carry   <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (clr) begin
                counter <= '0;
            end else if (load_req) begin
                counter <= load_digit;
            end else if (tick) begin
                if (dir) begin
                    if (counter >= MAX_D) begin
                        counter <= '0;
                        carry   <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end else begin
                    if (counter == '0) begin
                        counter <= MAX_D;
                        carry   <= 1'b1;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
            end
        end
    end

endmodule
